riscv_regfile: RTL and testbench

//   RV32I integer register file: the write-back stage writes into it, and decode reads it.

---
 rtl/riscv_regfile.sv | 108 ++++++++++
 tb/tb_riscv_regfile.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile.sv
// riscv_regfile: RV32I integer register file.
// Write port driven by the write-back stage, two combinational read ports for
// decode, a req/ack debug read port and a free-running count of retired writes.
// Optional build macro: RISCV_REGFILE_BYPASS_EN (write-through on the read ports).

`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile #(
  parameter int REG_ADDR_W = 5,
  parameter int WRCNT_W    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_ctrl_reg_wr_enW,
  input  logic [REG_ADDR_W-1:0] i_regfile_rd_addrW,
  input  logic [`XLEN-1:0]      i_regfile_rd_dataW,
  input  logic [REG_ADDR_W-1:0] i_rs1_addrD,
  input  logic [REG_ADDR_W-1:0] i_rs2_addrD,
  output logic [`XLEN-1:0]      o_rs1_dataD,
  output logic [`XLEN-1:0]      o_rs2_dataD,
  input  logic                  i_dbg_req,
  input  logic [REG_ADDR_W-1:0] i_dbg_addr,
  output logic                  o_dbg_ack,
  output logic [`XLEN-1:0]      o_dbg_data,
  output logic [WRCNT_W-1:0]    o_wr_count
);

  localparam int NREG = 2 ** REG_ADDR_W;

  // Debug handshake: i_dbg_req is a single-cycle qualifier sampled at a rising
  // edge; that same edge registers o_dbg_ack=1 for exactly one cycle together
  // with the register value as it was before any write landing on that edge.
  // There is no backpressure: a request every cycle gives an ack every cycle.
  // Without a request o_dbg_ack is 0 and o_dbg_data keeps its last value.

  // Entry 0 is never written, so it stays a constant zero after reset.
  logic [`XLEN-1:0]   regs_q [NREG];
  logic [`XLEN-1:0]   regs_d [NREG];
  logic               dbg_ack_q, dbg_ack_d;
  logic [`XLEN-1:0]   dbg_data_q, dbg_data_d;
  logic [WRCNT_W-1:0] wr_count_q, wr_count_d;
  logic               wr_accept;

  // A write is only real when enabled and aimed at a register other than x0.
  assign wr_accept = i_ctrl_reg_wr_enW && (i_regfile_rd_addrW != '0);

  // Next-state for the register array and the retired-write counter.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    wr_count_d = wr_count_q;
    if (wr_accept) begin
      regs_d[i_regfile_rd_addrW] = i_regfile_rd_dataW;
      wr_count_d                 = wr_count_q + WRCNT_W'(1);
    end
  end

  // Next-state for the debug response: sample the stored (pre-write) value.
  always_comb begin
    dbg_ack_d  = i_dbg_req;
    dbg_data_d = dbg_data_q;
    if (i_dbg_req) begin
      dbg_data_d = (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
    end
  end

  // Decode read ports: zero-latency lookup, x0 hard-wired to zero.
  always_comb begin
    o_rs1_dataD = (i_rs1_addrD == '0) ? '0 : regs_q[i_rs1_addrD];
    o_rs2_dataD = (i_rs2_addrD == '0) ? '0 : regs_q[i_rs2_addrD];
`ifdef RISCV_REGFILE_BYPASS_EN
    // wr_accept already excludes rd=0, so x0 reads can never be overridden.
    if (wr_accept && (i_rs1_addrD == i_regfile_rd_addrW)) begin
      o_rs1_dataD = i_regfile_rd_dataW;
    end
    if (wr_accept && (i_rs2_addrD == i_regfile_rd_addrW)) begin
      o_rs2_dataD = i_regfile_rd_dataW;
    end
`endif
  end

  // State registers; asynchronous reset also drops any pending debug ack.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign o_dbg_ack  = dbg_ack_q;
  assign o_dbg_data = dbg_data_q;
  assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_riscv_regfile.sv
// Testbench for riscv_regfile: directed steps plus random traffic against an
// array-based reference model. A second instance with a 4-bit counter shares
// the same stimulus to exercise counter wrap.

`timescale 1ns/1ps

module tb_riscv_regfile;

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        dreq;
  logic [4:0]  daddr;
  logic        ack;
  logic [31:0] dbg_data;
  logic [31:0] wr_count;
  logic [31:0] rs1_data4, rs2_data4;
  logic        ack4;
  logic [31:0] dbg_data4;
  logic [3:0]  wr_count4;

  // Reference model state
  logic [31:0] mregs [32];
  int unsigned mcnt;
  logic        exp_ack;
  logic [31:0] exp_dbg;

  int total = 0;
  int bad   = 0;

  riscv_regfile u_dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_ctrl_reg_wr_enW  (wr_en),
    .i_regfile_rd_addrW (rd),
    .i_regfile_rd_dataW (wd),
    .i_rs1_addrD        (rs1),
    .i_rs2_addrD        (rs2),
    .o_rs1_dataD        (rs1_data),
    .o_rs2_dataD        (rs2_data),
    .i_dbg_req          (dreq),
    .i_dbg_addr         (daddr),
    .o_dbg_ack          (ack),
    .o_dbg_data         (dbg_data),
    .o_wr_count         (wr_count)
  );

  riscv_regfile #(.REG_ADDR_W(5), .WRCNT_W(4)) u_dut4 (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_ctrl_reg_wr_enW  (wr_en),
    .i_regfile_rd_addrW (rd),
    .i_regfile_rd_dataW (wd),
    .i_rs1_addrD        (rs1),
    .i_rs2_addrD        (rs2),
    .o_rs1_dataD        (rs1_data4),
    .o_rs2_dataD        (rs2_data4),
    .i_dbg_req          (dreq),
    .i_dbg_addr         (daddr),
    .o_dbg_ack          (ack4),
    .o_dbg_data         (dbg_data4),
    .o_wr_count         (wr_count4)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result recorder: the comparison itself is made at each call site.
  task automatic check(input string tag, input bit ok,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of a decode read as seen during the current cycle.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : mregs[a];
`ifdef RISCV_REGFILE_BYPASS_EN
    if (wr_en && rd != 0 && rd == a) v = wd;
`endif
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcnt    = 0;
    exp_ack = 1'b0;
    exp_dbg = 32'h0;
  endfunction

  // One clock: check combinational reads, then advance the model on the edge
  // and check the registered outputs just after it.
  task automatic cycle();
    logic [31:0] e1, e2;
    e1 = model_read(rs1);
    e2 = model_read(rs2);
    #1;
    check("rs1_data", rs1_data === e1, rs1_data, e1);
    check("rs2_data", rs2_data === e2, rs2_data, e2);
    @(posedge clk);
    if (dreq) begin
      exp_ack = 1'b1;
      exp_dbg = (daddr == 0) ? 32'h0 : mregs[daddr];
    end else begin
      exp_ack = 1'b0;
    end
    if (wr_en && rd != 0) begin
      mregs[rd] = wd;
      mcnt++;
    end
    #1;
    check("dbg_ack", ack === exp_ack, 32'(ack), 32'(exp_ack));
    check("dbg_data", dbg_data === exp_dbg, dbg_data, exp_dbg);
    check("wr_count", wr_count === 32'(mcnt), wr_count, 32'(mcnt));
    check("wr_count4", wr_count4 === 4'(mcnt % 16), 32'(wr_count4), 32'(mcnt % 16));
  endtask

  // Asynchronous reset applied mid-cycle; every register read back while held.
  task automatic reset_dut();
    rstn = 1'b0;
    model_clear();
    #1;
    check("rst_ack", ack === 1'b0, 32'(ack), 32'h0);
    check("rst_ack4", ack4 === 1'b0, 32'(ack4), 32'h0);
    check("rst_dbg_data", dbg_data === 32'h0, dbg_data, 32'h0);
    check("rst_wr_count", wr_count === 32'h0, wr_count, 32'h0);
    check("rst_wr_count4", wr_count4 === 4'h0, 32'(wr_count4), 32'h0);
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a);
      rs2 = 5'(31 - a);
      #1;
      check("rst_rs1", rs1_data === 32'h0, rs1_data, 32'h0);
      check("rst_rs2", rs2_data === 32'h0, rs2_data, 32'h0);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd = '0; wd = '0; dreq = 1'b0; daddr = '0;
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0;
    model_clear();

    // Reset, then read every address on both ports and the debug port.
    reset_dut();
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(31 - a); dreq = 1'b1; daddr = 5'(a);
      cycle();
    end
    idle();

    // x5 = DEADBEEF, then a discarded write to x0.
    wr_en = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF; rs1 = 5'd5; rs2 = 5'd0;
    cycle();
    wr_en = 1'b1; rd = 5'd0; wd = 32'h1234; rs1 = 5'd5; rs2 = 5'd0;
    cycle();
    idle(); rs1 = 5'd5; rs2 = 5'd0;
    cycle();
    check("x5_direct", rs1_data === 32'hDEADBEEF, rs1_data, 32'hDEADBEEF);
    check("x0_direct", rs2_data === 32'h0, rs2_data, 32'h0);
    check("count_after_x0", wr_count === 32'd1, wr_count, 32'd1);
    rs1 = 5'd5; rs2 = 5'd5;
    cycle();

    // Same-cycle write/read collision on x7, then the next cycle.
    wr_en = 1'b1; rd = 5'd7; wd = 32'hA5A5A5A5; rs1 = 5'd7; rs2 = 5'd0;
    cycle();
    idle(); rs1 = 5'd7;
    cycle();

    // Back-to-back debug reads 5, 7, 0 followed by an idle cycle.
    dreq = 1'b1; daddr = 5'd5; cycle();
    check("dbg_seq0", dbg_data === 32'hDEADBEEF, dbg_data, 32'hDEADBEEF);
    dreq = 1'b1; daddr = 5'd7; cycle();
    check("dbg_seq1", dbg_data === 32'hA5A5A5A5, dbg_data, 32'hA5A5A5A5);
    dreq = 1'b1; daddr = 5'd0; cycle();
    check("dbg_seq2", dbg_data === 32'h0, dbg_data, 32'h0);
    idle(); cycle();

    // Debug sample racing a write to the same register: pre-write value.
    wr_en = 1'b1; rd = 5'd5; wd = 32'h0BADF00D; dreq = 1'b1; daddr = 5'd5;
    cycle();
    idle();

    // Counter wrap: fresh reset, 17 accepted writes with x0 writes interleaved.
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; rd = 5'(1 + (i % 31)); wd = $urandom; rs1 = rd; rs2 = 5'(i);
      cycle();
      wr_en = 1'b1; rd = 5'd0; wd = $urandom;
      cycle();
    end
    idle();
    cycle();
    check("wrap_count4", wr_count4 === 4'd1, 32'(wr_count4), 32'd1);
    check("wrap_count32", wr_count === 32'd17, wr_count, 32'd17);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr_en = ($urandom_range(0, 9) < 6);
      rd    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2   = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      dreq  = ($urandom_range(0, 1) == 1);
      daddr = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      cycle();
    end

    // Debug request, then reset asserted during the following cycle.
    idle();
    dreq = 1'b1; daddr = 5'd3;
    cycle();
    check("pre_rst_ack", ack === 1'b1, 32'(ack), 32'd1);
    idle();
    #2;
    reset_dut();
    dreq = 1'b1; daddr = 5'($urandom_range(1, 31)); rs1 = daddr;
    cycle();
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
